ddc_nco_mixer: RTL and testbench
================================

DDC_NCO_MIXER -- requirements
Module: ddc_nco_mixer

Interface
REQ-001 Parameter DATA_W, default 14, input and output sample width (signed two's complement).
REQ-002 Parameter PHASE_W, default 16, phase accumulator width.
REQ-003 Parameter LUT_AW, default 6, quarter-wave table resolution: N = 2^LUT_AW steps per quadrant.
REQ-004 Parameter COEF_W, default 12, signed sine/cosine coefficient width; amplitude A = 2^(COEF_W-1)-1.
REQ-005 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 in_valid  input  1  data_in carries a sample this cycle.
REQ-008 data_in  input  DATA_W  signed real input sample.
REQ-009 phase_inc  input  PHASE_W  unsigned NCO tuning word; f_nco = fs_valid * phase_inc / 2^PHASE_W.
REQ-010 phase_clr  input  1  synchronous phase accumulator clear.
REQ-011 out_valid  output  1  one-cycle strobe; down_data_i and down_data_q are new this cycle.
REQ-012 down_data_i  output  DATA_W  signed in-phase product.
REQ-013 down_data_q  output  DATA_W  signed quadrature product.

Function
REQ-014 Sample phase SHALL be the accumulator value before update; on in_valid, acc <= acc + phase_inc, modulo 2^PHASE_W (silent wrap).
REQ-015 Without in_valid the accumulator SHALL hold; phase advances per sample, not per clock.
REQ-016 phase_clr with in_valid low: acc <= 0. phase_clr with in_valid high: the sample uses phase 0 and acc <= phase_inc.
REQ-017 phase_inc SHALL be sampled on each in_valid cycle; a change takes effect on the next valid sample, with no phase discontinuity.
REQ-018 Phase index p = top LUT_AW+2 bits of the sample phase; quadrant qd = p[LUT_AW+1:LUT_AW]; idx = remaining LUT_AW bits.
REQ-019 Table S[k], k = 0..N (N+1 entries), SHALL hold round(A*sin(pi*k/(2N))); S[0] = 0 and S[N] = A.
REQ-020 sin(p) by quadrant: qd0 -> S[idx]; qd1 -> S[N-idx]; qd2 -> -S[idx]; qd3 -> -S[N-idx]. cos(p) = sin(p+N mod 4N).
REQ-021 Products: I = data_in*cos; Q = -(data_in*sin). Each is a full DATA_W+COEF_W signed product, scaled right by COEF_W-1 bits.
REQ-022 Pipeline: stage 1 registers data and phase index; stage 2 registers coefficients and data; stage 3 registers the rounded products. in_valid to out_valid latency SHALL be exactly 3 clk.
REQ-023 Throughput SHALL be one sample per clk; no backpressure; back-to-back in_valid SHALL be accepted.
REQ-024 Outputs SHALL hold their last value when out_valid is low; out_valid SHALL be high only in the cycle a new result is registered.
REQ-025 The scaled result SHALL fit in DATA_W bits for all inputs because |coef| <= A; no saturation logic.

Reset
REQ-026 On rst: acc = 0, all pipeline valid flags = 0, and out_valid, down_data_i, down_data_q = 0.
REQ-027 Asserting rst mid-stream SHALL discard in-flight samples; no out_valid for them after release.
REQ-028 The first in_valid after reset release SHALL use phase 0.

Configuration
REQ-029 Macro DDC_ROUND_EN defined: add 2^(COEF_W-2) before the arithmetic right shift (round half up).
REQ-030 DDC_ROUND_EN undefined: plain arithmetic right shift (truncation toward minus infinity); latency unchanged.

Verification (defaults, DDC_ROUND_EN defined unless stated)
REQ-031 phase_inc = 16384, data_in = 1000 constant, in_valid high -> I = 1000,0,-1000,0,...; Q = 0,-1000,0,1000,...; first out_valid 3 cycles after the first in_valid.
REQ-032 Same stimulus with DDC_ROUND_EN undefined -> I = 999,0,-1000,0,... (1000*2047 >> 11 = 999).
REQ-033 in_valid on alternate cycles with phase_inc = 16384 -> outputs match REQ-031 per sample; out_valid alternates; outputs hold in gaps.
REQ-034 phase_inc = 32768, 5 samples, then phase_clr with in_valid, data_in = 1000 -> the cleared sample gives I = 1000, Q = 0.
REQ-035 Assert rst with 2 samples in flight -> outputs = 0 immediately, no out_valid for them; next sample after release uses phase 0.
REQ-036 data_in = -8192, phase_inc = 0 -> I = -8188, Q = 0; no overflow.

Source files
------------

// File: rtl/ddc_nco_mixer.sv
// ddc_nco_mixer: digital down-converter front end.
// A phase accumulator advances once per accepted sample. Its top bits index a
// quarter-wave sine table to produce the cosine/sine coefficients, which mix the
// real input into I/Q. Three register stages give a fixed 3-clk latency at one
// sample per clock.
// Build option: define DDC_ROUND_EN to round half-up before the final scaling
// shift; otherwise the shift truncates toward minus infinity.
module ddc_nco_mixer #(
    parameter int DATA_W  = 14,
    parameter int PHASE_W = 16,
    parameter int LUT_AW  = 6,
    parameter int COEF_W  = 12
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic signed [DATA_W-1:0]  data_in,
    input  logic [PHASE_W-1:0]        phase_inc,
    input  logic                      phase_clr,
    output logic                      out_valid,
    output logic signed [DATA_W-1:0]  down_data_i,
    output logic signed [DATA_W-1:0]  down_data_q
);

    localparam int P_W    = LUT_AW + 2;
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int N      = 1 << LUT_AW;
    localparam int AMP    = (1 << (COEF_W - 1)) - 1;
    localparam real PI    = 3.14159265358979323846;
    localparam logic [LUT_AW:0]  LUT_N   = (LUT_AW + 1)'(N);
    localparam logic [P_W-1:0]   QUARTER = P_W'(N);
`ifdef DDC_ROUND_EN
    localparam logic signed [PROD_W-1:0] RND_HALF = PROD_W'(1 << (COEF_W - 2));
`endif

    // Quarter-wave table S[k] = round(A*sin(pi*k/(2N))), k = 0..N.
    logic signed [COEF_W-1:0] sin_lut [0:N];

    for (genvar k = 0; k <= N; k++) begin : g_lut
        localparam int VAL = int'(real'(AMP) * $sin(PI * real'(k) / real'(2 * N)));
        assign sin_lut[k] = COEF_W'(VAL);
    end

    // Registered state
    logic [PHASE_W-1:0]       acc_q,      acc_d;
    logic                     s1_valid_q, s1_valid_d;
    logic signed [DATA_W-1:0] s1_data_q,  s1_data_d;
    logic [P_W-1:0]           s1_p_q,     s1_p_d;
    logic                     s2_valid_q, s2_valid_d;
    logic signed [DATA_W-1:0] s2_data_q,  s2_data_d;
    logic signed [COEF_W-1:0] s2_sin_q,   s2_sin_d;
    logic signed [COEF_W-1:0] s2_cos_q,   s2_cos_d;
    logic                     out_valid_q, out_valid_d;
    logic signed [DATA_W-1:0] out_i_q,    out_i_d;
    logic signed [DATA_W-1:0] out_q_q,    out_q_d;

    // Combinational intermediates
    logic [P_W-1:0]           cos_p;
    logic [LUT_AW:0]          sin_addr;
    logic [LUT_AW:0]          cos_addr;
    logic signed [COEF_W-1:0] sin_mag;
    logic signed [COEF_W-1:0] cos_mag;
    logic signed [PROD_W-1:0] prod_i;
    logic signed [PROD_W-1:0] prod_q;
    logic signed [PROD_W-1:0] rnd_i;
    logic signed [PROD_W-1:0] rnd_q;

    // Phase accumulator and stage-1 capture of data and phase index
    always_comb begin
        acc_d      = acc_q;
        s1_valid_d = in_valid;
        s1_data_d  = data_in;
        // The sample uses the pre-update accumulator; a clear forces phase 0.
        s1_p_d     = phase_clr ? '0 : acc_q[PHASE_W-1 -: P_W];
        if (phase_clr) begin
            acc_d = in_valid ? phase_inc : '0;
        end else if (in_valid) begin
            acc_d = acc_q + phase_inc;
        end
    end

    // Stage 2: quadrant folding of the quarter-wave table into sin/cos
    always_comb begin
        cos_p    = s1_p_q + QUARTER;
        sin_addr = s1_p_q[LUT_AW] ? LUT_N - {1'b0, s1_p_q[LUT_AW-1:0]}
                                  : {1'b0, s1_p_q[LUT_AW-1:0]};
        cos_addr = cos_p[LUT_AW] ? LUT_N - {1'b0, cos_p[LUT_AW-1:0]}
                                 : {1'b0, cos_p[LUT_AW-1:0]};
        sin_mag  = sin_lut[sin_addr];
        cos_mag  = sin_lut[cos_addr];
        s2_sin_d   = s1_p_q[P_W-1] ? -sin_mag : sin_mag;
        s2_cos_d   = cos_p[P_W-1]  ? -cos_mag : cos_mag;
        s2_data_d  = s1_data_q;
        s2_valid_d = s1_valid_q;
    end

    // Stage 3: full-width products, optional rounding, scale back to DATA_W
    always_comb begin
        prod_i = PROD_W'(s2_data_q) * PROD_W'(s2_cos_q);
        prod_q = -(PROD_W'(s2_data_q) * PROD_W'(s2_sin_q));
`ifdef DDC_ROUND_EN
        rnd_i  = prod_i + RND_HALF;
        rnd_q  = prod_q + RND_HALF;
`else
        rnd_i  = prod_i;
        rnd_q  = prod_q;
`endif
        out_valid_d = s2_valid_q;
        out_i_d     = out_i_q;
        out_q_d     = out_q_q;
        if (s2_valid_q) begin
            // |coef| <= A keeps the scaled result inside DATA_W bits.
            out_i_d = DATA_W'(rnd_i >>> (COEF_W - 1));
            out_q_d = DATA_W'(rnd_q >>> (COEF_W - 1));
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q       <= '0;
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s1_p_q      <= '0;
            s2_valid_q  <= 1'b0;
            s2_data_q   <= '0;
            s2_sin_q    <= '0;
            s2_cos_q    <= '0;
            out_valid_q <= 1'b0;
            out_i_q     <= '0;
            out_q_q     <= '0;
        end else begin
            acc_q       <= acc_d;
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            s1_p_q      <= s1_p_d;
            s2_valid_q  <= s2_valid_d;
            s2_data_q   <= s2_data_d;
            s2_sin_q    <= s2_sin_d;
            s2_cos_q    <= s2_cos_d;
            out_valid_q <= out_valid_d;
            out_i_q     <= out_i_d;
            out_q_q     <= out_q_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign down_data_i = out_i_q;
    assign down_data_q = out_q_q;

endmodule

// File: tb/tb_ddc_nco_mixer.sv
// Scoreboard bench for ddc_nco_mixer: stimulus pushes hand-computed I/Q
// results, a negedge monitor pops them on out_valid and checks hold/reset.
module tb_ddc_nco_mixer;

    localparam int DATA_W  = 14;
    localparam int PHASE_W = 16;
    localparam int LUT_AW  = 6;
    localparam int COEF_W  = 12;

    // 1000*2047 scaled by 2^-11 is 999.5: rounds to 1000, truncates to 999.
`ifdef DDC_ROUND_EN
    localparam int POS = 1000;
    localparam int Q16 = -382;
`else
    localparam int POS = 999;
    localparam int Q16 = -383;
`endif
    localparam int NEG = -1000;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     in_valid = 1'b0;
    logic                     phase_clr = 1'b0;
    logic signed [DATA_W-1:0] data_in = '0;
    logic [PHASE_W-1:0]       phase_inc = '0;
    logic                     out_valid;
    logic signed [DATA_W-1:0] down_data_i;
    logic signed [DATA_W-1:0] down_data_q;

    always #5 clk = ~clk;

    ddc_nco_mixer #(
        .DATA_W (DATA_W),
        .PHASE_W(PHASE_W),
        .LUT_AW (LUT_AW),
        .COEF_W (COEF_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .data_in    (data_in),
        .phase_inc  (phase_inc),
        .phase_clr  (phase_clr),
        .out_valid  (out_valid),
        .down_data_i(down_data_i),
        .down_data_q(down_data_q)
    );

    typedef struct {
        int i;
        int q;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   last_i = 0;
    int   last_q = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: reset values, scoreboard pops on out_valid, hold otherwise
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            check("rst_valid", int'(out_valid), 0);
            check("rst_i", int'(down_data_i), 0);
            check("rst_q", int'(down_data_q), 0);
            last_i = 0;
            last_q = 0;
        end else if (out_valid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid: got out_valid=1 expected 0 (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                check("data_i", int'(down_data_i), e.i);
                check("data_q", int'(down_data_q), e.q);
                check("latency", cyc - e.cyc, 3);
                last_i = e.i;
                last_q = e.q;
            end
        end else begin
            check("hold_i", int'(down_data_i), last_i);
            check("hold_q", int'(down_data_q), last_q);
        end
    end

    task automatic send(input int d, input int inc, input bit clr, input bit push,
                        input int ei, input int eq);
        exp_t e;
        data_in   = DATA_W'(d);
        phase_inc = PHASE_W'(inc);
        phase_clr = clr;
        in_valid  = 1'b1;
        if (push) begin
            e.i = ei;
            e.q = eq;
            e.cyc = cyc;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        phase_clr = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    int pat_i [4];
    int pat_q [4];

    initial begin
        pat_i = '{POS, 0, NEG, 0};
        pat_q = '{0, NEG, 0, POS};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        // Quarter-rate tone, back-to-back samples
        for (int k = 0; k < 8; k++) send(1000, 16384, 1'b0, 1'b1, pat_i[k % 4], pat_q[k % 4]);

        // Same tone on alternate cycles; phase advances per sample only
        for (int k = 0; k < 8; k++) begin
            send(1000, 16384, 1'b0, 1'b1, pat_i[k % 4], pat_q[k % 4]);
            idle(1);
        end

        // Half-rate tone, then a clear that coincides with a sample
        for (int k = 0; k < 5; k++) send(1000, 32768, 1'b0, 1'b1, (k % 2) ? NEG : POS, 0);
        send(1000, 32768, 1'b1, 1'b1, POS, 0);

        // Clear without a sample, then fine steps through interior table entries
        phase_clr = 1'b1;
        idle(1);
        phase_clr = 1'b0;
        send(1000, 2048, 1'b0, 1'b1, POS, 0);
        send(1000, 2048, 1'b0, 1'b1, 980, -195);
        send(1000, 2048, 1'b0, 1'b1, 923, Q16);

        // Most negative input at phase 0
        send(-8192, 0, 1'b1, 1'b1, -8188, 0);
        send(-8192, 0, 1'b0, 1'b1, -8188, 0);
        idle(5);

        // Reset with two samples in flight
        send(1000, 16384, 1'b0, 1'b0, 0, 0);
        send(1000, 16384, 1'b0, 1'b0, 0, 0);
        rst = 1'b1;
        #1;
        check("async_rst_valid", int'(out_valid), 0);
        check("async_rst_i", int'(down_data_i), 0);
        check("async_rst_q", int'(down_data_q), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(3);
        send(1000, 16384, 1'b0, 1'b1, POS, 0);
        send(1000, 16384, 1'b0, 1'b1, 0, NEG);

        // Drain with a bounded wait
        for (int t = 0; t < 20 && sb.size() != 0; t++) @(posedge clk);
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: got %0d pending results expected 0", sb.size());
        end
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
